// File: rtl/shvram_arbiter.sv
// rtl/shvram_arbiter.sv - N-CPU shared video-RAM arbiter and region decoder
//
// Purpose:
//   Decodes each CPU memory cycle against NREGION address windows, grants the
//   VRAM to one CPU at a time and drives registered chip selects, address and
//   strobes toward the VRAMs. Losing or in-progress CPUs are held via wait_n.
//   Sequence per access: IDLE -> GRANT (ACCESS_CYCLES clocks) -> RELEASE -> IDLE.
//
// Configuration macro:
//   SHVRAM_FIXED_PRIO_EN  defined   : lowest CPU index always wins arbitration
//                         undefined : round-robin starting after the last owner
//
// Ports:
//   clk      in   1             system clock
//   reset    in   1             synchronous active-high reset
//   mreq_n   in   NCPU          per-CPU memory request, active low
//   rd_n     in   NCPU          per-CPU read strobe, active low
//   wr_n     in   NCPU          per-CPU write strobe, active low
//   addr     in   NCPU*AW       packed CPU addresses, CPU c = [c*AW +: AW]
//   wait_n   out  NCPU          per-CPU wait, low stalls the CPU
//   cs_n     out  NREGION       registered region chip selects, active low
//   vaddr    out  VAW           registered VRAM address
//   vrd_n    out  1             registered VRAM read strobe, active low
//   vwr_n    out  1             registered VRAM write strobe, active low
//   owner    out  OW            index of the currently granted CPU
//   busy     out  1             high in GRANT and RELEASE

module shvram_arbiter #(
  parameter int                       NCPU          = 2,
  parameter int                       AW            = 16,
  parameter int                       VAW           = 11,
  parameter int                       NREGION       = 4,
  parameter logic [NREGION*AW-1:0]    REGION_BASE   = '0,
  parameter logic [NREGION*AW-1:0]    REGION_MASK   = '0,
  parameter logic [NREGION*NCPU-1:0]  REGION_CPU    = '1,
  parameter int                       ACCESS_CYCLES = 2,
  localparam int                      OW            = (NCPU > 1) ? $clog2(NCPU) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCPU-1:0]      mreq_n,
  input  logic [NCPU-1:0]      rd_n,
  input  logic [NCPU-1:0]      wr_n,
  input  logic [NCPU*AW-1:0]   addr,
  output logic [NCPU-1:0]      wait_n,
  output logic [NREGION-1:0]   cs_n,
  output logic [VAW-1:0]       vaddr,
  output logic                 vrd_n,
  output logic                 vwr_n,
  output logic [OW-1:0]        owner,
  output logic                 busy
);

  localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [VAW-1:0]       vaddr_q, vaddr_d;
  logic [NREGION-1:0]   cs_n_q, cs_n_d;
  logic                 vrd_n_q, vrd_n_d;
  logic                 vwr_n_q, vwr_n_d;

  logic [NCPU-1:0][NREGION-1:0] hit;
  logic [NCPU-1:0][NREGION-1:0] sel_oh;
  logic [NCPU-1:0]              valid;
  logic [NCPU-1:0]              sel_found;

  logic [OW-1:0]        win;
  logic                 win_found;
  logic [AW-1:0]        win_addr;
  logic [NREGION-1:0]   win_sel;
  logic                 win_rd_n;
  logic                 win_wr_n;
  logic                 cnt_last;

  // Region decode: a window only counts as a hit for CPUs allowed into it,
  // and among several permitted hits only the lowest-index window is kept.
  always_comb begin
    hit       = '0;
    sel_oh    = '0;
    sel_found = '0;
    for (int c = 0; c < NCPU; c++) begin
      for (int r = 0; r < NREGION; r++) begin
        hit[c][r] = ((addr[c*AW +: AW] & REGION_MASK[r*AW +: AW]) ==
                     (REGION_BASE[r*AW +: AW] & REGION_MASK[r*AW +: AW])) &&
                    REGION_CPU[r*NCPU + c];
        if (hit[c][r] && !sel_found[c]) begin
          sel_oh[c][r] = 1'b1;
          sel_found[c] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    for (int c = 0; c < NCPU; c++) begin
      valid[c] = ~mreq_n[c] & (~rd_n[c] | ~wr_n[c]) & sel_found[c];
    end
  end

`ifdef SHVRAM_FIXED_PRIO_EN
  // Fixed priority: scan from the top so the lowest valid index is left last.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int c = NCPU - 1; c >= 0; c--) begin
      if (valid[c]) begin
        win       = OW'(c);
        win_found = 1'b1;
      end
    end
  end
`else
  // Round-robin: rr_q holds the CPU index the next search starts from.
  logic [OW-1:0] rr_q, rr_d;

  always_comb begin
    win       = '0;
    win_found = 1'b0;
    for (int i = 0; i < NCPU; i++) begin
      if (!win_found) begin
        if ((int'(rr_q) + i) >= NCPU) begin
          if (valid[int'(rr_q) + i - NCPU]) begin
            win       = OW'(int'(rr_q) + i - NCPU);
            win_found = 1'b1;
          end
        end else begin
          if (valid[int'(rr_q) + i]) begin
            win       = OW'(int'(rr_q) + i);
            win_found = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (state_q == S_IDLE && win_found) begin
      rr_d = (int'(win) == NCPU - 1) ? '0 : win + OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Fields of the winning CPU, captured into the output registers at grant.
  always_comb begin
    win_addr = '0;
    win_sel  = '0;
    win_rd_n = 1'b1;
    win_wr_n = 1'b1;
    for (int c = 0; c < NCPU; c++) begin
      if (win == OW'(c)) begin
        win_addr = addr[c*AW +: AW];
        win_sel  = sel_oh[c];
        win_rd_n = rd_n[c];
        win_wr_n = wr_n[c];
      end
    end
  end

  assign cnt_last = (cnt_q == CW'(ACCESS_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    vaddr_d = vaddr_q;
    cs_n_d  = cs_n_q;
    vrd_n_d = vrd_n_q;
    vwr_n_d = vwr_n_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d = S_GRANT;
          cnt_d   = '0;
          owner_d = win;
          vaddr_d = win_addr[VAW-1:0];
          cs_n_d  = ~win_sel;
          // Both strobes low is a write: suppress the read strobe.
          vwr_n_d = win_wr_n;
          vrd_n_d = win_rd_n | ~win_wr_n;
        end
      end
      S_GRANT: begin
        // Either the access completed or the owner walked away: close it out.
        if (cnt_last || !valid[owner_q]) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
          cs_n_d  = '1;
          vrd_n_d = 1'b1;
          vwr_n_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cs_n_d  = '1;
        vrd_n_d = 1'b1;
        vwr_n_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= '0;
      vaddr_q <= '0;
      cs_n_q  <= '1;
      vrd_n_q <= 1'b1;
      vwr_n_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      vaddr_q <= vaddr_d;
      cs_n_q  <= cs_n_d;
      vrd_n_q <= vrd_n_d;
      vwr_n_q <= vwr_n_d;
    end
  end

  // A CPU is released for exactly the last clock of its own access; any
  // other CPU with a valid cycle is stalled. Reset releases everyone.
  always_comb begin
    wait_n = '1;
    if (!reset) begin
      for (int c = 0; c < NCPU; c++) begin
        wait_n[c] = ~valid[c] |
                    ((state_q == S_GRANT) && (owner_q == OW'(c)) && cnt_last);
      end
    end
  end

  assign cs_n  = cs_n_q;
  assign vaddr = vaddr_q;
  assign vrd_n = vrd_n_q;
  assign vwr_n = vwr_n_q;
  assign owner = owner_q;
  assign busy  = (state_q != S_IDLE);

endmodule
